// File: rtl/signed_adder_arbiter_if.sv
// signed_adder_arbiter_if
//   Request/response bundle between NUM_REQ datapath clients and the shared
//   signed adder.
//   req_valid [NUM_REQ]         per-requester operand valid
//   req_a/req_b [NUM_REQ*DATA_W] packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready [NUM_REQ]         one-hot grant/accept
//   rsp_valid/rsp_ready         response handshake
//   rsp_sum [DATA_W]            signed sum (two's complement)
//   rsp_id  [ID_W]              requester that produced rsp_sum
//   rsp_ovf                     signed overflow of that add
//   master: client/consumer side; slave: the arbiter.
interface signed_adder_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_sum;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, rsp_ovf
  );
endinterface

// File: rtl/signed_adder_arbiter.sv
// signed_adder_arbiter
//   One registered signed DATA_W-bit adder shared by NUM_REQ requesters
//   under round-robin arbitration. Sequence per operation: IDLE (grant and
//   latch operands), ADD (register sum/overflow/id), RESP (hold result
//   until the consumer takes it).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - signed_adder_arbiter_if.slave (request and response channels)
// Build option:
//   SIGNED_ADDER_ARBITER_SAT_EN - when defined, an overflowing sum clamps
//   to the most positive / most negative value instead of wrapping.
//   rsp_ovf is the same in both builds.
module signed_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  signed_adder_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t                     state_q, state_d;
  logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic signed [DATA_W-1:0]   op_a_q, op_a_d;
  logic signed [DATA_W-1:0]   op_b_q, op_b_d;
  logic [ID_W-1:0]            id_q, id_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic signed [DATA_W-1:0]   rsp_sum_q, rsp_sum_d;
  logic [ID_W-1:0]            rsp_id_q, rsp_id_d;
  logic                       rsp_ovf_q, rsp_ovf_d;

  logic                       grant_found;
  logic [ID_W-1:0]            grant_id;
  logic [NUM_REQ-1:0]         req_ready_c;
  logic signed [DATA_W-1:0]   sum_wrap;
  logic                       sum_ovf;

  // Overflow is only possible when both operands share a sign and the
  // truncated result disagrees with it.
  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

`ifdef SIGNED_ADDER_ARBITER_SAT_EN
  function automatic logic signed [DATA_W-1:0] sat_sum(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] s,
    input logic                     ovf);
    if (!ovf)
      return s;
    else if (a[DATA_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction
`endif

  // Round-robin search: first valid at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  assign sum_wrap = op_a_q + op_b_q;
  assign sum_ovf  = add_ovf(op_a_q, op_b_q, sum_wrap);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    rsp_ovf_d   = rsp_ovf_q;
    req_ready_c = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_c = NUM_REQ'(1) << grant_id;
          op_a_d      = bus.req_a[int'(grant_id)*DATA_W +: DATA_W];
          op_b_d      = bus.req_b[int'(grant_id)*DATA_W +: DATA_W];
          id_d        = grant_id;
          state_d     = ADD;
        end
      end
      ADD: begin
`ifdef SIGNED_ADDER_ARBITER_SAT_EN
        rsp_sum_d   = sat_sum(op_a_q, sum_wrap, sum_ovf);
`else
        rsp_sum_d   = sum_wrap;
`endif
        rsp_ovf_d   = sum_ovf;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = ID_W'((int'(rsp_id_q) + 1) % NUM_REQ);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  // Operand capture; only meaningful after a grant, so not reset
  always_ff @(posedge clk) begin
    op_a_q <= op_a_d;
    op_b_q <= op_b_d;
    id_q   <= id_d;
  end

  assign bus.req_ready = rst ? '0 : req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_signed_adder_arbiter.sv
// tb_signed_adder_arbiter
//   Directed bench for signed_adder_arbiter (NUM_REQ=4, DATA_W=8, ID_W=2).
//   Inputs change 1 time unit after a rising edge; outputs are sampled
//   after they settle, away from the edge.
module tb_signed_adder_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;

`ifdef SIGNED_ADDER_ARBITER_SAT_EN
  localparam logic [7:0] EXP_POS_OVF = 8'h7F;
  localparam logic [7:0] EXP_NEG_OVF = 8'h80;
`else
  localparam logic [7:0] EXP_POS_OVF = 8'h80;
  localparam logic [7:0] EXP_NEG_OVF = 8'h7F;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  signed_adder_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  signed_adder_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[idx*DATA_W +: DATA_W] = a;
    bus.req_b[idx*DATA_W +: DATA_W] = b;
  endtask

  // Single transaction from an idle arbiter with the consumer always ready.
  task automatic run_one(input string t, input int idx, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_sum,
                         input logic exp_ovf);
    set_ops(idx, a, b);
    bus.req_valid = 4'(1) << idx;
    bus.rsp_ready = 1'b1;
    #1;
    check({t, "_grant"}, 32'(bus.req_ready), 32'(4'(1) << idx));
    tick();
    bus.req_valid = '0;
    check({t, "_add_vld"}, 32'(bus.rsp_valid), 32'(0));
    check({t, "_add_rdy"}, 32'(bus.req_ready), 32'(0));
    tick();
    check({t, "_vld"}, 32'(bus.rsp_valid), 32'(1));
    check({t, "_sum"}, 32'(bus.rsp_sum), 32'(exp_sum));
    check({t, "_id"},  32'(bus.rsp_id), 32'(idx));
    check({t, "_ovf"}, 32'(bus.rsp_ovf), 32'(exp_ovf));
    tick();
    check({t, "_done"}, 32'(bus.rsp_valid), 32'(0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_vld", 32'(bus.rsp_valid), 32'(0));
    check("rst_sum", 32'(bus.rsp_sum), 32'(0));
    check("rst_id",  32'(bus.rsp_id), 32'(0));
    check("rst_ovf", 32'(bus.rsp_ovf), 32'(0));
    check("rst_rdy", 32'(bus.req_ready), 32'(0));
    bus.req_valid = '0;
    rst = 1'b0;
    tick();

    // Arithmetic cases; rr_ptr moves 0 -> 1 -> 3 -> 2 -> 0 along the way
    run_one("max",   0, 8'd100, 8'd27, 8'd127, 1'b0);
    run_one("povf",  2, 8'd100, 8'd28, EXP_POS_OVF, 1'b1);
    run_one("novf",  1, 8'h80,  8'hFF, EXP_NEG_OVF, 1'b1);
    run_one("neg",   3, 8'hCE,  8'h14, 8'hE2, 1'b0);

    // Round robin with every requester pending
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, 8'(i * 10), 8'(i));
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 8; n++) begin
      int e;
      e = n % NUM_REQ;
      check("rr_grant", 32'(bus.req_ready), 32'(4'(1) << e));
      tick();
      tick();
      check("rr_vld", 32'(bus.rsp_valid), 32'(1));
      check("rr_id",  32'(bus.rsp_id), 32'(e));
      check("rr_sum", 32'(bus.rsp_sum), 32'(e * 11));
      tick();
    end

    // Backpressure: requester 1 alone, consumer stalls 5 cycles
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    #1;
    check("bp_grant", 32'(bus.req_ready), 32'(4'b0010));
    tick();
    tick();
    for (int n = 0; n < 5; n++) begin
      check("bp_vld", 32'(bus.rsp_valid), 32'(1));
      check("bp_sum", 32'(bus.rsp_sum), 32'(11));
      check("bp_id",  32'(bus.rsp_id), 32'(1));
      check("bp_ovf", 32'(bus.rsp_ovf), 32'(0));
      check("bp_rdy", 32'(bus.req_ready), 32'(0));
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_acc_vld", 32'(bus.rsp_valid), 32'(0));
    check("bp_next_grant", 32'(bus.req_ready), 32'(4'b0010));
    tick();
    bus.req_valid = '0;
    tick();
    check("bp2_vld", 32'(bus.rsp_valid), 32'(1));
    check("bp2_id",  32'(bus.rsp_id), 32'(1));
    tick();

    // Reset while in ADD discards the operation
    set_ops(2, 8'd7, 8'd8);
    bus.req_valid = 4'b0100;
    #1;
    check("ra_grant", 32'(bus.req_ready), 32'(4'b0100));
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    check("ra_rdy_in_rst", 32'(bus.req_ready), 32'(0));
    tick();
    check("ra_vld", 32'(bus.rsp_valid), 32'(0));
    check("ra_sum", 32'(bus.rsp_sum), 32'(0));
    check("ra_id",  32'(bus.rsp_id), 32'(0));
    check("ra_ovf", 32'(bus.rsp_ovf), 32'(0));
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("ra_no_rsp", 32'(bus.rsp_valid), 32'(0));
    end
    // rr_ptr back at 0: with 1 and 3 pending, 1 is chosen
    bus.req_valid = 4'b1010;
    #1;
    check("ra_ptr0", 32'(bus.req_ready), 32'(4'b0010));
    run_one("post_rst", 3, 8'd3, 8'd4, 8'd7, 1'b0);

    // Short request pulse during RESP must not be taken
    set_ops(0, 8'd1, 8'd2);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    #1;
    check("pl_grant", 32'(bus.req_ready), 32'(4'b0001));
    tick();
    bus.req_valid = '0;
    tick();
    check("pl_vld", 32'(bus.rsp_valid), 32'(1));
    check("pl_sum", 32'(bus.rsp_sum), 32'(3));
    bus.req_valid = 4'b0010;
    #1;
    check("pl_rdy_resp", 32'(bus.req_ready), 32'(0));
    tick();
    bus.req_valid = '0;
    check("pl_hold", 32'(bus.rsp_valid), 32'(1));
    bus.rsp_ready = 1'b1;
    tick();
    check("pl_acc_vld", 32'(bus.rsp_valid), 32'(0));
    check("pl_keep_sum", 32'(bus.rsp_sum), 32'(3));
    check("pl_keep_id", 32'(bus.rsp_id), 32'(0));
    for (int n = 0; n < 3; n++) begin
      check("pl_idle_rdy", 32'(bus.req_ready), 32'(0));
      tick();
      check("pl_idle_vld", 32'(bus.rsp_valid), 32'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
